// File: rtl/alu181_pkg.sv
// rtl/alu181_pkg.sv - shared types and operation encodings for the serial 74181 sequencer
// Purpose: sequencer state enum and the S/M/Cn encodings of the common operations.
// Ports: none (package).
package alu181_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Cn is the raw 74181 carry input: 1 means "no carry in".
  localparam logic [3:0] ADD_S  = 4'b1001;
  localparam logic       ADD_M  = 1'b0;
  localparam logic       ADD_CN = 1'b1;

  // SUB yields A-B; CMP yields A-B-1, i.e. all ones when A == B.
  localparam logic [3:0] SUB_S  = 4'b0110;
  localparam logic       SUB_M  = 1'b0;
  localparam logic       SUB_CN = 1'b0;

  localparam logic [3:0] CMP_S  = 4'b0110;
  localparam logic       CMP_M  = 1'b0;
  localparam logic       CMP_CN = 1'b1;

  // Logic-mode operations ignore Cn.
  localparam logic [3:0] XOR_S  = 4'b0110;
  localparam logic       XOR_M  = 1'b1;

  localparam logic [3:0] AND_S  = 4'b1011;
  localparam logic       AND_M  = 1'b1;

endpackage

// File: rtl/ALU_74181_comb.sv
// rtl/ALU_74181_comb.sv - combinational 4-bit 74181-style ALU slice (active-high data)
// Purpose: one 4-bit 74181 slice evaluated combinationally.
// Ports:
//   a_i, b_i [3:0]  operands
//   s_i [3:0]       function select
//   m_i             mode: 0 arithmetic, 1 logic
//   cn_i            raw carry-in (active-low carry)
//   f_o [3:0]       result
//   cn4_o           raw carry-out Cn+4 (active-low carry)
//   aeqb_o          A=B output (AND of the F bits)
module ALU_74181_comb (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] s_i,
  input  logic       m_i,
  input  logic       cn_i,
  output logic [3:0] f_o,
  output logic       cn4_o,
  output logic       aeqb_o
);

  logic [3:0] e_n;  // complement of per-bit generate
  logic [3:0] d_n;  // complement of per-bit propagate
  logic [4:0] c;    // active-high internal carries

  always_comb begin
    e_n  = ~((a_i & b_i & {4{s_i[3]}}) | (a_i & ~b_i & {4{s_i[2]}}));
    d_n  = ~(a_i | (b_i & {4{s_i[0]}}) | (~b_i & {4{s_i[1]}}));
    c    = '0;
    c[0] = ~cn_i;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = ~e_n[i] | (~d_n[i] & c[i]);
    end
    // e_n ^ d_n is the half-sum of A and the selected B term; logic mode
    // presents its complement so that e.g. S=0110 gives A xor B.
    f_o = m_i ? ~(e_n ^ d_n) : (e_n ^ d_n ^ c[3:0]);
  end

  assign cn4_o  = ~c[4];
  assign aeqb_o = &f_o;

endmodule

// File: rtl/alu181_serial_seq.sv
// rtl/alu181_serial_seq.sv - nibble-serial 74181 operation sequencer
// Purpose: runs a WIDTH-bit 74181 operation through one 4-bit slice, LSB nibble
//   first, one nibble per clock, with the slice carry chained through a register.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          operation request handshake
//   a, b [WIDTH-1:0]           operands, latched on accept
//   s [3:0], m, cn             74181 select, mode, raw carry-in, latched on accept
//   out_valid/out_ready        result handshake
//   f [WIDTH-1:0]              result
//   cn_out                     raw Cn+4 of the last nibble
//   a_eq_b                     AND of the slice A=B outputs over all nibbles
module alu181_serial_seq
  import alu181_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic [3:0]           s,
  input  logic                 m,
  input  logic                 cn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] f,
  output logic                 cn_out,
  output logic                 a_eq_b
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, res_q, res_d, f_q;
  logic [3:0]        s_q;
  logic              m_q;
  logic              carry_q;   // raw (active-low) carry into the current nibble
  logic              eq_q;
  logic [IDXW-1:0]   idx_q;
  logic              cn_out_q, aeq_q;

  logic [3:0]        slice_f;
  logic              slice_cn4, slice_eq;
  logic              accept, last_nib;

  ALU_74181_comb u_slice (
    .a_i    (a_q[{idx_q, 2'b00} +: 4]),
    .b_i    (b_q[{idx_q, 2'b00} +: 4]),
    .s_i    (s_q),
    .m_i    (m_q),
    .cn_i   (carry_q),
    .f_o    (slice_f),
    .cn4_o  (slice_cn4),
    .aeqb_o (slice_eq)
  );

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign last_nib  = (idx_q == LAST_IDX);
  assign out_valid = (state_q == DONE);
  assign f         = f_q;
  assign cn_out    = cn_out_q;
  assign a_eq_b    = aeq_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    res_d[{idx_q, 2'b00} +: 4] = slice_f;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      idx_q    <= '0;
      res_q    <= '0;
      f_q      <= '0;
      cn_out_q <= 1'b0;
      aeq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        a_q     <= a;
        b_q     <= b;
        s_q     <= s;
        m_q     <= m;
        carry_q <= cn;
        eq_q    <= 1'b1;
        idx_q   <= '0;
        res_q   <= '0;
      end
      if (state_q == RUN) begin
        res_q   <= res_d;
        carry_q <= slice_cn4;
        eq_q    <= eq_q & slice_eq;
        idx_q   <= idx_q + IDXW'(1);
        // Outputs move only on the final nibble so they stay stable through DONE
        // and keep their values after the handshake.
        if (last_nib) begin
          f_q      <= res_d;
          cn_out_q <= slice_cn4;
          aeq_q    <= eq_q & slice_eq;
        end
      end
    end
  end

endmodule
